// File: rtl/clk_div_gen_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_gen_pkg
// Shared types and helpers for the clk_div_gen clock-enable generator.
//   lock_state_t : lock FSM states (WARMUP, RUN)
//   cfg_state_t  : config FSM states (IDLE, PEND)
//   MIN_DIV      : smallest legal divide ratio
//   clamp_div    : raises ratios below MIN_DIV to MIN_DIV
//   clamp_phase  : limits a phase offset to ratio-1
// ---------------------------------------------------------------------------
package clk_div_gen_pkg;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } lock_state_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } cfg_state_t;

    localparam int MIN_DIV = 2;

    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
    endfunction

    // d is assumed already clamped, so d-1 never underflows.
    function automatic logic [31:0] clamp_phase(input logic [31:0] p, input logic [31:0] d);
        return (p >= d) ? (d - 32'd1) : p;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// ---------------------------------------------------------------------------
// clk_div_chan
// One output channel: divide ratio and period counter, the load-on-boundary
// logic for a pending reconfiguration, and the output flops.
// Phase offset support is compiled in with CLK_DIV_GEN_PHASE_EN.
//
// Ports
//   clkin        in   clock
//   reset        in   async active-high reset
//   i_run        in   lock FSM currently in RUN
//   i_run_next   in   lock FSM will be in RUN next cycle
//   i_upd        in   a pending update targets this channel
//   i_new_div    in   pending (clamped) divide ratio
//   i_new_phase  in   pending (clamped) phase offset (macro only)
//   o_boundary   out  this cycle is the last cycle of the current period
//   o_clk_en     out  one-cycle strobe at cnt==0
//   o_clk_div    out  square wave, high while cnt < div/2
// ---------------------------------------------------------------------------
module clk_div_chan
    import clk_div_gen_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 32
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             i_run,
    input  logic             i_run_next,
    input  logic             i_upd,
    input  logic [DIV_W-1:0] i_new_div,
`ifdef CLK_DIV_GEN_PHASE_EN
    input  logic [DIV_W-1:0] i_new_phase,
`endif
    output logic             o_boundary,
    output logic             o_clk_en,
    output logic             o_clk_div
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_clk_en;
    logic             r_clk_div;

    logic             w_wrap;
    logic [DIV_W-1:0] w_load_cnt;
    logic [DIV_W-1:0] w_div_next;
    logic [DIV_W-1:0] w_cnt_next;
    logic             w_en_next;
    logic             w_div_out_next;

    // Starting count after an update; a phase of p delays the first strobe
    // of the new period by p cycles.
`ifdef CLK_DIV_GEN_PHASE_EN
    assign w_load_cnt = (i_new_phase == '0) ? '0 : (i_new_div - i_new_phase);
`else
    assign w_load_cnt = '0;
`endif

    always_comb begin
        w_wrap     = (r_cnt == (r_div - DIV_W'(1)));
        w_div_next = r_div;
        w_cnt_next = '0;
        if (i_run) begin
            if (w_wrap) begin
                if (i_upd) begin
                    w_div_next = i_new_div;
                    w_cnt_next = w_load_cnt;
                end
            end else begin
                w_cnt_next = r_cnt + DIV_W'(1);
            end
        end
        // Outputs are registered from next-state values so they line up
        // with the count they describe.
        w_en_next      = i_run_next && (w_cnt_next == '0);
        w_div_out_next = i_run_next && (w_cnt_next < (w_div_next >> 1));
    end

    assign o_boundary = i_run && w_wrap;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_div     <= DIV_W'(DEFAULT_DIV);
            r_cnt     <= '0;
            r_clk_en  <= 1'b0;
            r_clk_div <= 1'b0;
        end else begin
            r_div     <= w_div_next;
            r_cnt     <= w_cnt_next;
            r_clk_en  <= w_en_next;
            r_clk_div <= w_div_out_next;
        end
    end

    assign o_clk_en  = r_clk_en;
    assign o_clk_div = r_clk_div;

endmodule

// File: rtl/clk_div_gen.sv
// ---------------------------------------------------------------------------
// clk_div_gen
// Multi-channel clock-enable generator. Holds all channels idle during a
// warm-up period after reset, then runs NCH independent dividers. Ratio (and
// optionally phase) updates are queued and applied at the target channel's
// period boundary so no runt pulses are produced.
// Optional feature macro: CLK_DIV_GEN_PHASE_EN adds cfg_phase.
//
// Ports
//   clkin      in   sole clock, rising edge
//   reset      in   async active-high reset
//   cfg_valid  in   reconfiguration request
//   cfg_ready  out  request accepted when cfg_valid && cfg_ready
//   cfg_ch     in   target channel
//   cfg_div    in   new divide ratio (values < 2 become 2)
//   cfg_phase  in   new phase offset (macro only, clamped to div-1)
//   clk_en     out  per-channel one-cycle strobe per period
//   clk_div    out  per-channel divided square wave
//   lock       out  channels running
// ---------------------------------------------------------------------------
module clk_div_gen
    import clk_div_gen_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int DEFAULT_DIV = 32
) (
    input  logic                                  clkin,
    input  logic                                  reset,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]                      cfg_div,
`ifdef CLK_DIV_GEN_PHASE_EN
    input  logic [DIV_W-1:0]                      cfg_phase,
`endif
    output logic [NCH-1:0]                        clk_en,
    output logic [NCH-1:0]                        clk_div,
    output logic                                  lock
);

    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int WARM_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(LOCK_CYCLES - 1);

    lock_state_t      r_lock_state;
    logic [WARM_W-1:0] r_warm;
    logic             r_lock;

    cfg_state_t       r_cfg_state;
    logic             r_ready;
    logic [CH_W-1:0]  r_pend_ch;
    logic [DIV_W-1:0] r_pend_div;
`ifdef CLK_DIV_GEN_PHASE_EN
    logic [DIV_W-1:0] r_pend_phase;
    logic [DIV_W-1:0] w_cfg_phase_cl;
`endif

    logic             w_run_next;
    logic             w_ch_valid;
    logic             w_applied;
    logic [DIV_W-1:0] w_cfg_div_cl;
    logic [NCH-1:0]   w_upd;
    logic [NCH-1:0]   w_boundary;

    // RUN is sticky, so next-cycle run is simply "already running or the
    // warm-up down-counter has reached terminal count".
    assign w_run_next = (r_lock_state == RUN) || (r_warm == '0);

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_lock_state <= WARMUP;
            r_warm       <= WARM_INIT;
            r_lock       <= 1'b0;
        end else begin
            case (r_lock_state)
                WARMUP: begin
                    if (r_warm == '0) begin
                        r_lock_state <= RUN;
                        r_lock       <= 1'b1;
                    end else begin
                        r_warm <= r_warm - WARM_W'(1);
                    end
                end
                RUN: begin
                    r_lock <= 1'b1;
                end
            endcase
        end
    end

    assign w_cfg_div_cl = DIV_W'(clamp_div(32'(cfg_div)));
`ifdef CLK_DIV_GEN_PHASE_EN
    assign w_cfg_phase_cl = DIV_W'(clamp_phase(32'(cfg_phase), 32'(w_cfg_div_cl)));
`endif

    assign w_ch_valid = (int'(r_pend_ch) < NCH);
    assign w_applied  = |(w_boundary & w_upd);

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_cfg_state  <= IDLE;
            r_ready      <= 1'b0;
            r_pend_ch    <= '0;
            r_pend_div   <= DIV_W'(MIN_DIV);
`ifdef CLK_DIV_GEN_PHASE_EN
            r_pend_phase <= '0;
`endif
        end else begin
            case (r_cfg_state)
                IDLE: begin
                    if (cfg_valid && r_ready) begin
                        r_cfg_state  <= PEND;
                        r_ready      <= 1'b0;
                        r_pend_ch    <= cfg_ch;
                        r_pend_div   <= w_cfg_div_cl;
`ifdef CLK_DIV_GEN_PHASE_EN
                        r_pend_phase <= w_cfg_phase_cl;
`endif
                    end else begin
                        r_ready <= w_run_next;
                    end
                end
                PEND: begin
                    // An out-of-range channel is dropped after one cycle.
                    if (!w_ch_valid || w_applied) begin
                        r_cfg_state <= IDLE;
                        r_ready     <= w_run_next;
                    end
                end
            endcase
        end
    end

    assign cfg_ready = r_ready;
    assign lock      = r_lock;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        assign w_upd[g] = (r_cfg_state == PEND) && (int'(r_pend_ch) == g);

        clk_div_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clkin       (clkin),
            .reset       (reset),
            .i_run       (r_lock),
            .i_run_next  (w_run_next),
            .i_upd       (w_upd[g]),
            .i_new_div   (r_pend_div),
`ifdef CLK_DIV_GEN_PHASE_EN
            .i_new_phase (r_pend_phase),
`endif
            .o_boundary  (w_boundary[g]),
            .o_clk_en    (clk_en[g]),
            .o_clk_div   (clk_div[g])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
module tb_clk_div_gen;

    localparam int NCH = 3;

    typedef struct {
        int cyc;
        int hi;
    } exp_t;

    logic           clkin;
    logic           reset;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_ch;
    logic [7:0]     cfg_div;
`ifdef CLK_DIV_GEN_PHASE_EN
    logic [7:0]     cfg_phase;
`endif
    logic [NCH-1:0] clk_en;
    logic [NCH-1:0] clk_div;
    logic           lock;

    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t q[NCH][$];
    int   hicnt[NCH];
    int   open_hi[NCH];
    bit   open_p[NCH];

    clk_div_gen #(
        .NCH         (NCH),
        .DIV_W       (8),
        .LOCK_CYCLES (16),
        .DEFAULT_DIV (32)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
`ifdef CLK_DIV_GEN_PHASE_EN
        .cfg_phase (cfg_phase),
`endif
        .clk_en    (clk_en),
        .clk_div   (clk_div),
        .lock      (lock)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // cyc = number of rising edges since reset release
    always @(posedge clkin or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expected strobe whenever a channel presents clk_en and
    // checks the clk_div high count of the period just closed.
    always @(negedge clkin) begin
        exp_t e;
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                open_p[i] = 1'b0;
                hicnt[i]  = 0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                while (q[i].size() > 0 && q[i][0].cyc < cyc) begin
                    e = q[i].pop_front();
                    check($sformatf("strobe_missed_ch%0d", i), cyc, e.cyc);
                end
                if (clk_en[i]) begin
                    if (open_p[i] && open_hi[i] >= 0)
                        check($sformatf("div_high_ch%0d", i), hicnt[i], open_hi[i]);
                    check($sformatf("strobe_expected_ch%0d", i), int'(q[i].size() > 0), 1);
                    if (q[i].size() > 0) begin
                        e = q[i].pop_front();
                        check($sformatf("strobe_cyc_ch%0d", i), cyc, e.cyc);
                        open_hi[i] = e.hi;
                        open_p[i]  = 1'b1;
                    end else begin
                        open_p[i] = 1'b0;
                    end
                    hicnt[i] = clk_div[i] ? 1 : 0;
                end else if (clk_div[i]) begin
                    hicnt[i]++;
                end
            end
        end
    end

    task automatic push_seq(input int ch, input int first, input int step, input int last, input int hi);
        for (int c = first; c <= last; c += step) q[ch].push_back('{c, hi});
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clkin);
    endtask

    task automatic send(input int ch, input int dv, input int ph);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = 8'(dv);
`ifdef CLK_DIV_GEN_PHASE_EN
        cfg_phase = 8'(ph);
`else
        if (ph != 0) $display("note: phase ignored without phase feature");
`endif
        @(negedge clkin);
        cfg_valid = 1'b0;
    endtask

    task automatic check_queues_empty(input string tag);
        for (int i = 0; i < NCH; i++)
            check($sformatf("%s_left_ch%0d", tag, i), q[i].size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
`ifdef CLK_DIV_GEN_PHASE_EN
        cfg_phase = '0;
`endif
        repeat (3) @(negedge clkin);
        check("rst_lock", int'(lock), 0);
        check("rst_ready", int'(cfg_ready), 0);
        check("rst_clk_en", int'(clk_en), 0);
        check("rst_clk_div", int'(clk_div), 0);

        // Schedule up to the mid-run reset at cycle 190.
        push_seq(0, 16, 32, 112, 16);
        push_seq(0, 144, 2, 190, 1);      // clamped ratio 2
        push_seq(1, 16, 32, 48, 16);
        push_seq(1, 80, 5, 190, 2);       // ratio 5 from the boundary at 79
        push_seq(2, 16, 32, 190, 16);
        #2 reset = 1'b0;

        wait_cyc(15);
        check("lock_before", int'(lock), 0);
        check("ready_before", int'(cfg_ready), 0);
        wait_cyc(16);
        check("lock_edge16", int'(lock), 1);
        check("ready_edge16", int'(cfg_ready), 1);

        // Mid-period update: ch1 div=5, 10 cycles into the period at 48.
        wait_cyc(58);
        check("ready_pre_upd1", int'(cfg_ready), 1);
        send(1, 5, 0);
        check("ready_pend_upd1", int'(cfg_ready), 0);
        wait_cyc(79);
        check("ready_boundary_upd1", int'(cfg_ready), 0);
        wait_cyc(80);
        check("ready_after_upd1", int'(cfg_ready), 1);

        // Ratio clamp: ch0 div=0 becomes 2.
        wait_cyc(120);
        send(0, 0, 0);
        check("ready_pend_clamp", int'(cfg_ready), 0);
        wait_cyc(143);
        check("ready_boundary_clamp", int'(cfg_ready), 0);
        wait_cyc(144);
        check("ready_after_clamp", int'(cfg_ready), 1);

        // Invalid channel: accepted, dropped after one cycle.
        wait_cyc(160);
        check("ready_pre_inval", int'(cfg_ready), 1);
        send(3, 7, 0);
        check("ready_pend_inval", int'(cfg_ready), 0);
        wait_cyc(162);
        check("ready_after_inval", int'(cfg_ready), 1);

        // Reset while ch2 div=9 is pending (boundary would be 207).
        wait_cyc(180);
        check("ready_pre_rst", int'(cfg_ready), 1);
        send(2, 9, 0);
        check("ready_pend_rst", int'(cfg_ready), 0);
        wait_cyc(190);
        #2 reset = 1'b1;
        #1;
        check("midrst_lock", int'(lock), 0);
        check("midrst_ready", int'(cfg_ready), 0);
        check("midrst_clk_en", int'(clk_en), 0);
        check("midrst_clk_div", int'(clk_div), 0);
        check_queues_empty("pre_rst");
        for (int i = 0; i < NCH; i++) q[i].delete();

        repeat (3) @(negedge clkin);
`ifdef CLK_DIV_GEN_PHASE_EN
        push_seq(0, 16, 32, 144, 16);
        q[0].push_back('{179, -1});       // div=8 phase=3 after boundary 175
        q[0].push_back('{194, 4});        // phase 9 -> 7 after boundary 186
        q[0].push_back('{202, 4});
`else
        push_seq(0, 16, 32, 208, 16);
`endif
        push_seq(1, 16, 32, 208, 16);
        push_seq(2, 16, 32, 208, 16);     // pending ratio 9 must not appear
        #2 reset = 1'b0;

        wait_cyc(15);
        check("lock2_before", int'(lock), 0);
        wait_cyc(16);
        check("lock2_edge16", int'(lock), 1);
        check("ready2_edge16", int'(cfg_ready), 1);

`ifdef CLK_DIV_GEN_PHASE_EN
        wait_cyc(150);
        send(0, 8, 3);
        wait_cyc(176);
        check("ready_after_ph3", int'(cfg_ready), 1);
        wait_cyc(180);
        send(0, 8, 9);
        wait_cyc(187);
        check("ready_after_ph9", int'(cfg_ready), 1);
`endif

        wait_cyc(210);
        check_queues_empty("end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
